// File: rtl/wts_slot_pkg.sv
// Shared types and constants for the MSX slot bus front-end of the wave-table cartridge.
package wts_slot_pkg;

    localparam int         C_SYNC_STAGES  = 2;
    localparam int         C_READ_TIMEOUT = 15;
    localparam logic [7:0] C_OPEN_BUS     = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_END   = 2'd1,
        S_RD_WAIT  = 2'd2,
        S_RD_DRIVE = 2'd3
    } slot_state_e;

endpackage

// File: rtl/wts_sync_ff.sv
// Multi-flop synchroniser for one asynchronous slot strobe; resets to the inactive (high) level.
module wts_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the raw strobe one stage deeper each clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // synchroniser flops, reset to the idle-high strobe level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b1}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wts_slot_bus_if.sv
// Slot bus front-end: synchronises MSX strobes, turns each memory access to this slot into
// one bus_write/bus_read pulse, and returns read data (or open-bus 0xFF) onto slot_d.
module wts_slot_bus_if
    import wts_slot_pkg::*;
#(
    parameter int SYNC_STAGES  = C_SYNC_STAGES,
    parameter int READ_TIMEOUT = C_READ_TIMEOUT
) (
    input  logic        clk,
    input  logic        slot_nreset,
    input  logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    input  logic        slot_nsltsl,
    input  logic        slot_nmerq,
    input  logic        slot_nrd,
    input  logic        slot_nwr,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_wdata,
    output logic        bus_write,
    output logic        bus_read,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_valid
);

    localparam logic [3:0] C_TIMEOUT = 4'(READ_TIMEOUT);

    logic nsltsl_s, nmerq_s, nrd_s, nwr_s, sel_s;

    wts_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_nsltsl (.clk(clk), .rst_n(slot_nreset), .d(slot_nsltsl), .q(nsltsl_s));
    wts_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_nmerq  (.clk(clk), .rst_n(slot_nreset), .d(slot_nmerq),  .q(nmerq_s));
    wts_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_nrd    (.clk(clk), .rst_n(slot_nreset), .d(slot_nrd),    .q(nrd_s));
    wts_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_nwr    (.clk(clk), .rst_n(slot_nreset), .d(slot_nwr),    .q(nwr_s));

    assign sel_s = ~nsltsl_s & ~nmerq_s;

    slot_state_e state_q, state_d;
    logic [3:0]  timer_q, timer_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  dout_q, dout_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        oe_q, oe_d;

    // access decode: one request pulse per strobe assertion, then wait for the strobe to end
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        write_d = 1'b0;
        read_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_s && !nwr_s) begin
                    addr_d  = slot_a;
                    wdata_d = slot_d_in;
                    write_d = 1'b1;
                    state_d = S_WR_END;
                end else if (sel_s && !nrd_s) begin
                    addr_d  = slot_a;
                    read_d  = 1'b1;
                    timer_d = 4'd0;
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_END: begin
                if (nwr_s || !sel_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_END;
                end
            end
            S_RD_WAIT: begin
                if (bus_rdata_valid) begin
                    dout_d  = bus_rdata;
                    state_d = S_RD_DRIVE;
                end else if (timer_q == C_TIMEOUT) begin
                    dout_d  = C_OPEN_BUS;
                    state_d = S_RD_DRIVE;
                end else if (nrd_s || !sel_s) begin
                    state_d = S_IDLE;
                end else if (timer_q != 4'hF) begin
                    timer_d = timer_q + 4'd1;
                end else begin
                    timer_d = timer_q;
                end
            end
            S_RD_DRIVE: begin
                if (nrd_s || !sel_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        oe_d = (state_d == S_RD_DRIVE);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) begin
            state_q <= S_IDLE;
            timer_q <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            dout_q  <= C_OPEN_BUS;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            write_q <= write_d;
            read_q  <= read_d;
            oe_q    <= oe_d;
        end
    end

    assign bus_address = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_write   = write_q;
    assign bus_read    = read_q;
    assign slot_d_out  = dout_q;
    // raw pins gate the driver so the bus is freed as soon as the host lifts nrd or nsltsl
    assign slot_d_oe   = oe_q & ~slot_nrd & ~slot_nsltsl;

endmodule
